// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, requester IDs and default widths.
package cpu_defs;

    localparam int unsigned DEF_ADDR_W  = 28;
    localparam int unsigned DEF_BLOCK_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT_I = 3'd1,
        ST_GRANT_D = 3'd2,
        ST_DONE_I  = 3'd3,
        ST_DONE_D  = 3'd4
    } arb_state_t;

    // Requester IDs double as bit positions in request/exclude vectors.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Two-way combinational picker: masks excluded requesters, breaks ties with the pointer.
module arb_pick
    import cpu_defs::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] excl_i,
    input  logic       ptr_i,
    output logic       gnt_id_c_o,
    output logic       gnt_valid_c_o
);

    logic [1:0] eff;

    always_comb begin
        eff           = req_i & ~excl_i;
        gnt_valid_c_o = |eff;
        if (&eff) begin
            gnt_id_c_o = ptr_i;
        end else if (eff[REQ_D]) begin
            gnt_id_c_o = REQ_D;
        end else begin
            gnt_id_c_o = REQ_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache.
// ARB_ROUND_ROBIN_EN: round-robin tie-break in IDLE; otherwise fixed priority D over I.
module mem_port_arbiter
    import cpu_defs::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned BLOCK_W = DEF_BLOCK_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDRESS,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDRESS,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,
    output logic               M_READ,
    output logic               M_WRITE,
    output logic [ADDR_W-1:0]  M_ADDRESS,
    output logic [BLOCK_W-1:0] M_WRITEDATA,
    input  logic [BLOCK_W-1:0] M_READDATA,
    input  logic               M_BUSYWAIT
);

    arb_state_t         state_q, state_d;
    logic               first_q, first_d;
    logic               m_read_q, m_read_d;
    logic               m_write_q, m_write_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [BLOCK_W-1:0] m_wdata_q, m_wdata_d;
    logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
    logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;
    logic [1:0]         req_vec, excl;
    logic               ptr, gnt_id, gnt_valid;

    // Request vector, and exclusion of the requester just served in DONE.
    always_comb begin
        req_vec        = 2'b00;
        req_vec[REQ_I] = I_READ;
        req_vec[REQ_D] = D_READ | D_WRITE;
        excl           = 2'b00;
        if (state_q == ST_DONE_I) excl[REQ_I] = 1'b1;
        if (state_q == ST_DONE_D) excl[REQ_D] = 1'b1;
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;

    // Pointer names the requester favoured on the next tie: the one not served last.
    always_comb begin
        rr_d = rr_q;
        if (state_q == ST_DONE_I) rr_d = REQ_D;
        if (state_q == ST_DONE_D) rr_d = REQ_I;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) rr_q <= REQ_I;
        else        rr_q <= rr_d;
    end

    assign ptr = rr_q;
`else
    assign ptr = REQ_D;
`endif

    arb_pick u_pick (
        .req_i        (req_vec),
        .excl_i       (excl),
        .ptr_i        (ptr),
        .gnt_id_c_o   (gnt_id),
        .gnt_valid_c_o(gnt_valid)
    );

    always_comb begin
        state_d   = state_q;
        first_d   = 1'b0;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            ST_GRANT_I, ST_GRANT_D: begin
                // Entry cycle is masked: memory may not have seen the request yet.
                if (!first_q && !M_BUSYWAIT) begin
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    if (state_q == ST_GRANT_I) begin
                        state_d = ST_DONE_I;
                        if (m_read_q && I_READ) i_rdata_d = M_READDATA;
                    end else begin
                        state_d = ST_DONE_D;
                        if (m_read_q && D_READ) d_rdata_d = M_READDATA;
                    end
                end
            end
            default: begin
                if (gnt_valid) begin
                    first_d = 1'b1;
                    if (gnt_id == REQ_D) begin
                        state_d   = ST_GRANT_D;
                        m_write_d = D_WRITE;
                        m_read_d  = ~D_WRITE;
                        m_addr_d  = D_ADDRESS;
                        m_wdata_d = D_WRITE ? D_WRITEDATA : '0;
                    end else begin
                        state_d   = ST_GRANT_I;
                        m_write_d = 1'b0;
                        m_read_d  = 1'b1;
                        m_addr_d  = I_ADDRESS;
                        m_wdata_d = '0;
                    end
                end else begin
                    state_d   = ST_IDLE;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            first_q   <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign M_READ      = m_read_q;
    assign M_WRITE     = m_write_q;
    assign M_ADDRESS   = m_addr_q;
    assign M_WRITEDATA = m_wdata_q;
    assign I_READDATA  = i_rdata_q;
    assign D_READDATA  = d_rdata_q;

    // Stalls follow the request level, drop only in the requester's DONE cycle, and clear in reset.
    assign I_BUSYWAIT = RESET & I_READ & (state_q != ST_DONE_I);
    assign D_BUSYWAIT = RESET & (D_READ | D_WRITE) & (state_q != ST_DONE_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory responder.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned BW = 128;
`ifdef ARB_ROUND_ROBIN_EN
    localparam logic TIE_FIRST_D = 1'b0;
`else
    localparam logic TIE_FIRST_D = 1'b1;
`endif

    logic          CLK = 1'b0;
    logic          RESET;
    logic          I_READ, D_READ, D_WRITE;
    logic [AW-1:0] I_ADDRESS, D_ADDRESS, M_ADDRESS;
    logic [BW-1:0] I_READDATA, D_READDATA, D_WRITEDATA, M_WRITEDATA, M_READDATA;
    logic          I_BUSYWAIT, D_BUSYWAIT, M_READ, M_WRITE, M_BUSYWAIT;

    int            n_cmp = 0;
    int            n_err = 0;
    int            mem_lat;
    int            mcnt;
    logic          force_low;
    logic [BW-1:0] mem_rdata;
    logic [3:0]    ctl;

    mem_port_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
        .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory is busy while a strobe is up until mem_lat cycles after it first saw it.
    always @(posedge CLK or negedge RESET) begin
        if (!RESET)                mcnt <= 0;
        else if (M_READ || M_WRITE) mcnt <= mcnt + 1;
        else                       mcnt <= 0;
    end
    assign M_BUSYWAIT = force_low ? 1'b0 : !((M_READ || M_WRITE) && (mcnt == mem_lat));
    assign M_READDATA = mem_rdata;
    assign ctl        = {M_READ, M_WRITE, I_BUSYWAIT, D_BUSYWAIT};

    task automatic test_reset();
        RESET = 1'b0; I_READ = 1'b1; D_READ = 1'b1;
        @(negedge CLK);
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, 4'b0000); end
        n_cmp++; if ({M_ADDRESS, M_WRITEDATA} !== '0) begin n_err++; $display("FAIL reset_maddr_wdata: got %h/%h want 0", M_ADDRESS, M_WRITEDATA); end
        n_cmp++; if ({I_READDATA, D_READDATA} !== '0) begin n_err++; $display("FAIL reset_readdata: got %h/%h want 0", I_READDATA, D_READDATA); end
        I_READ = 1'b0; D_READ = 1'b0;
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK);
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL idle_after_reset: got %b want %b", ctl, 4'b0000); end
    endtask

    task automatic test_i_read();
        logic [BW-1:0] rd = 128'hA5A5_0001_1234_5678_9ABC_DEF0_0F0F_C3C3;
        mem_lat = 4; mem_rdata = rd; I_ADDRESS = 28'h0000010; I_READ = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            n_cmp++; if ({ctl, M_ADDRESS} !== {4'b1010, 28'h0000010}) begin
                n_err++; $display("FAIL i_grant k=%0d: got %b/%h want 1010/0000010", k, ctl, M_ADDRESS); end
        end
        @(negedge CLK);
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL i_done_ctl: got %b want %b", ctl, 4'b0000); end
        n_cmp++; if (I_READDATA !== rd) begin n_err++; $display("FAIL i_readdata: got %h want %h", I_READDATA, rd); end
        I_READ = 1'b0; mem_rdata = '1;
        @(negedge CLK);
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL i_idle_ctl: got %b want %b", ctl, 4'b0000); end
        n_cmp++; if (I_READDATA !== rd) begin n_err++; $display("FAIL i_readdata_hold: got %h want %h", I_READDATA, rd); end
    endtask

    task automatic test_d_read();
        logic [BW-1:0] rd = 128'hDDDD_0000_1111_2222_3333_4444_5555_6666;
        mem_lat = 1; mem_rdata = rd; D_ADDRESS = 28'h0ABCDE0; D_READ = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge CLK);
            n_cmp++; if ({ctl, M_ADDRESS} !== {4'b1001, 28'h0ABCDE0}) begin
                n_err++; $display("FAIL d_grant k=%0d: got %b/%h want 1001/0abcde0", k, ctl, M_ADDRESS); end
        end
        @(negedge CLK);
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL d_done_ctl: got %b want %b", ctl, 4'b0000); end
        n_cmp++; if (D_READDATA !== rd) begin n_err++; $display("FAIL d_readdata: got %h want %h", D_READDATA, rd); end
        D_READ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_tie(input logic first_d, input logic [BW-1:0] wd, input logic [BW-1:0] rd,
                            input logic [AW-1:0] ai, input logic [AW-1:0] ad);
        logic          i_pend = 1'b1;
        logic          d_pend = 1'b1;
        logic          serve_d;
        logic [3:0]    exp;
        logic [AW-1:0] exp_a;
        mem_lat = 2; mem_rdata = rd;
        I_READ = 1'b1; I_ADDRESS = ai; D_WRITE = 1'b1; D_ADDRESS = ad; D_WRITEDATA = wd;
        for (int s = 0; s < 2; s++) begin
            serve_d = (s == 0) ? first_d : !first_d;
            exp   = {!serve_d, serve_d, i_pend, d_pend};
            exp_a = serve_d ? ad : ai;
            for (int k = 1; k <= 3; k++) begin
                @(negedge CLK);
                n_cmp++; if ({ctl, M_ADDRESS} !== {exp, exp_a}) begin
                    n_err++; $display("FAIL tie_grant s=%0d k=%0d: got %b/%h want %b/%h", s, k, ctl, M_ADDRESS, exp, exp_a); end
                if (serve_d) begin
                    n_cmp++; if (M_WRITEDATA !== wd) begin n_err++; $display("FAIL tie_wdata k=%0d: got %h want %h", k, M_WRITEDATA, wd); end
                end
            end
            @(negedge CLK);
            exp = {2'b00, serve_d ? i_pend : 1'b0, serve_d ? 1'b0 : d_pend};
            n_cmp++; if (ctl !== exp) begin n_err++; $display("FAIL tie_done s=%0d: got %b want %b", s, ctl, exp); end
            if (serve_d) begin D_WRITE = 1'b0; d_pend = 1'b0; end
            else begin I_READ = 1'b0; i_pend = 1'b0; end
        end
        @(negedge CLK);
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL tie_idle: got %b want %b", ctl, 4'b0000); end
        n_cmp++; if (I_READDATA !== rd) begin n_err++; $display("FAIL tie_i_readdata: got %h want %h", I_READDATA, rd); end
    endtask

    task automatic test_first_cycle();
        logic [BW-1:0] rd = 128'h0000_FFFF_0000_FFFF_1357_9BDF_2468_ACE0;
        force_low = 1'b1; mem_rdata = rd; I_ADDRESS = 28'h0000200; I_READ = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge CLK);
            n_cmp++; if ({ctl, M_ADDRESS} !== {4'b1010, 28'h0000200}) begin
                n_err++; $display("FAIL first_cycle_grant k=%0d: got %b/%h want 1010/0000200", k, ctl, M_ADDRESS); end
        end
        @(negedge CLK);
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL first_cycle_done: got %b want %b", ctl, 4'b0000); end
        n_cmp++; if (I_READDATA !== rd) begin n_err++; $display("FAIL first_cycle_data: got %h want %h", I_READDATA, rd); end
        I_READ = 1'b0; force_low = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] wd = 128'hBEEF_BEEF_0000_1111_CAFE_CAFE_2222_3333;
        logic [BW-1:0] rd = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
        mem_lat = 20; D_WRITE = 1'b1; D_ADDRESS = 28'h0000300; D_WRITEDATA = wd;
        for (int k = 1; k <= 2; k++) begin
            @(negedge CLK);
            n_cmp++; if ({ctl, M_ADDRESS, M_WRITEDATA} !== {4'b0101, 28'h0000300, wd}) begin
                n_err++; $display("FAIL rmid_grant k=%0d: got %b/%h/%h want 0101/0000300/%h", k, ctl, M_ADDRESS, M_WRITEDATA, wd); end
        end
        #2 RESET = 1'b0;
        #1;
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL rmid_async: got %b want %b", ctl, 4'b0000); end
        @(negedge CLK);
        RESET = 1'b1; D_WRITE = 1'b0; D_READ = 1'b1; D_ADDRESS = 28'h0000400; mem_lat = 1; mem_rdata = rd;
        for (int k = 1; k <= 2; k++) begin
            @(negedge CLK);
            n_cmp++; if ({ctl, M_ADDRESS} !== {4'b1001, 28'h0000400}) begin
                n_err++; $display("FAIL rmid_regrant k=%0d: got %b/%h want 1001/0000400", k, ctl, M_ADDRESS); end
        end
        @(negedge CLK);
        n_cmp++; if (ctl !== 4'b0000) begin n_err++; $display("FAIL rmid_done: got %b want %b", ctl, 4'b0000); end
        n_cmp++; if (D_READDATA !== rd) begin n_err++; $display("FAIL rmid_readdata: got %h want %h", D_READDATA, rd); end
        D_READ = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b0; I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
        I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0;
        mem_lat = 0; force_low = 1'b0; mem_rdata = '0;
        test_reset();
        test_i_read();
        test_d_read();
        test_tie(TIE_FIRST_D, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, 28'h0000020, 28'h0000030);
        test_tie(TIE_FIRST_D, 128'h8888_7777_6666_5555_4444_3333_2222_1111,
                 128'hF0E0_D0C0_B0A0_9080_7060_5040_3020_1000, 28'h0000040, 28'h0000050);
        test_first_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
